// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - recovers duty, phase and wrap flag of one PWM waveform per time-counter window
module pwm_capture #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] time_cnt,
    input  logic [WIDTH-1:0] cycle,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] phase,
    output logic             over,
    output logic             valid,
    output logic             err
);

    localparam int W1 = WIDTH + 1;

    logic             prev;
    logic             armed;
    logic             start_lvl;
    logic [1:0]       rise_cnt;
    logic [1:0]       fall_cnt;
    logic [WIDTH-1:0] l_pos;
    logic [WIDTH-1:0] r_pos;

    logic             dec_go;
    logic             d_s;
    logic [1:0]       d_rise;
    logic [1:0]       d_fall;
    logic [WIDTH-1:0] d_l;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] d_cycle;

    logic             rise;
    logic             fall;
    logic             open_win;
    logic             close_win;
    logic             live;
    logic [1:0]       base_rc;
    logic [1:0]       base_fc;
    logic [1:0]       n_rc;
    logic [1:0]       n_fc;
    logic [WIDTH-1:0] base_l;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] n_l;
    logic [WIDTH-1:0] n_r;
    logic             n_s;

    // Window statistics including the current sample; a TIME_CNT==0 sample restarts them.
    always_comb begin
        rise      = pwm_in & ~prev;
        fall      = ~pwm_in & prev;
        open_win  = (time_cnt == '0);
        close_win = (cycle != '0) && (time_cnt == cycle - WIDTH'(1));
        live      = open_win | armed;
        base_rc   = open_win ? 2'd0 : rise_cnt;
        base_fc   = open_win ? 2'd0 : fall_cnt;
        base_l    = open_win ? '0 : l_pos;
        base_r    = open_win ? '0 : r_pos;
        n_rc      = (rise && base_rc != 2'd2) ? base_rc + 2'd1 : base_rc;
        n_fc      = (fall && base_fc != 2'd2) ? base_fc + 2'd1 : base_fc;
        n_l       = (rise && base_rc == 2'd0) ? time_cnt : base_l;
        n_r       = (fall && base_fc == 2'd0) ? time_cnt : base_r;
        n_s       = open_win ? prev : start_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= 1'b0;
            armed     <= 1'b0;
            start_lvl <= 1'b0;
            rise_cnt  <= 2'd0;
            fall_cnt  <= 2'd0;
            l_pos     <= '0;
            r_pos     <= '0;
            dec_go    <= 1'b0;
            d_s       <= 1'b0;
            d_rise    <= 2'd0;
            d_fall    <= 2'd0;
            d_l       <= '0;
            d_r       <= '0;
            d_cycle   <= '0;
        end else begin
            prev      <= pwm_in;
            armed     <= live & ~close_win;
            start_lvl <= n_s;
            rise_cnt  <= n_rc;
            fall_cnt  <= n_fc;
            l_pos     <= n_l;
            r_pos     <= n_r;
            dec_go    <= live & close_win;
            // Snapshot frees the capture registers for the next window immediately.
            if (live && close_win) begin
                d_s     <= n_s;
                d_rise  <= n_rc;
                d_fall  <= n_fc;
                d_l     <= n_l;
                d_r     <= n_r;
                d_cycle <= cycle;
            end
        end
    end

    logic             bad;
    logic             no_edge;
    logic             dec_over;
    logic [W1-1:0]    cyc1;
    logic [W1-1:0]    l1;
    logic [W1-1:0]    r1;
    logic [W1-1:0]    dec_l;
    logic [W1-1:0]    dec_duty;
    logic [W1-1:0]    sum;
    logic [WIDTH-1:0] dec_phase;

    always_comb begin
        cyc1     = {1'b0, d_cycle};
        l1       = {1'b0, d_l};
        r1       = {1'b0, d_r};
        bad      = (d_rise == 2'd2) || (d_fall == 2'd2);
        no_edge  = (d_rise == 2'd0) && (d_fall == 2'd0);
        dec_l    = '0;
        dec_duty = '0;
        dec_over = 1'b0;
        if (no_edge) begin
            dec_duty = d_s ? cyc1 : '0;
        end else if (d_rise != 2'd0 && d_fall != 2'd0) begin
            dec_l = l1;
            if (r1 > l1) begin
                dec_duty = r1 - l1;
            end else begin
                dec_duty = r1 + cyc1 - l1;
                dec_over = 1'b1;
            end
        end else if (d_rise != 2'd0) begin
            dec_l    = l1;
            dec_duty = cyc1 - l1;
        end else begin
            dec_duty = r1;
        end
        sum = dec_l + (dec_duty >> 1);
        if (no_edge)
            dec_phase = '0;
        else if (sum >= cyc1)
            dec_phase = WIDTH'(sum - cyc1);
        else
            dec_phase = WIDTH'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty  <= '0;
            phase <= '0;
            over  <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= dec_go;
            if (dec_go) begin
                err <= bad;
                if (!bad) begin
                    duty  <= dec_duty[WIDTH-1:0];
                    phase <= dec_phase;
                    over  <= dec_over;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture driven by a loopback generator model
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] time_cnt = '0;
    logic [12:0] cycle = 13'd5000;
    logic        pwm_in = 1'b0;
    logic [12:0] duty;
    logic [12:0] phase;
    logic        over;
    logic        valid;
    logic        err;

    pwm_capture #(.WIDTH(13)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .time_cnt (time_cnt),
        .cycle    (cycle),
        .pwm_in   (pwm_in),
        .duty     (duty),
        .phase    (phase),
        .over     (over),
        .valid    (valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt = cnt + 1;

    typedef struct {
        int at;
        bit e;
        int d;
        int ph;
        bit ov;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cur_cycle = 5000;
    bit   m_prev = 0;
    bit   m_armed = 0;
    bit   m_s0 = 0;
    bit   win[$];
    int   hold_d = 0;
    int   hold_p = 0;
    int   hold_o = 0;
    bit   started = 0;

    task automatic chk(input string nm, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cnt);
        end
    endtask

    // Loopback generator: high on [ph - d/2, ph - d/2 + d) mod c.
    function automatic bit gen(input int d, input int ph, input int c, input int t);
        int st;
        st = (((ph - d / 2) % c) + c) % c;
        return ((t - st + c) % c) < d;
    endfunction

    // Reference decode of one full window from its sample list.
    function automatic exp_t decode_window(input int c);
        exp_t x;
        int   rs[$];
        int   fs[$];
        bit   last;
        int   l;
        last = m_s0;
        foreach (win[i]) begin
            if (win[i] && !last) rs.push_back(i);
            if (!win[i] && last) fs.push_back(i);
            last = win[i];
        end
        x.at = cnt + 2;
        x.e = 0; x.d = 0; x.ph = 0; x.ov = 0;
        if (rs.size() > 1 || fs.size() > 1) begin
            x.e = 1;
        end else if (rs.size() == 0 && fs.size() == 0) begin
            x.d = m_s0 ? c : 0;
        end else begin
            l = (rs.size() != 0) ? rs[0] : 0;
            if (rs.size() != 0 && fs.size() != 0) begin
                x.ov = fs[0] < l;
                x.d = x.ov ? fs[0] - l + c : fs[0] - l;
            end else if (rs.size() != 0) begin
                x.d = c - l;
            end else begin
                x.d = fs[0];
            end
            x.ph = (l + x.d / 2) % c;
        end
        return x;
    endfunction

    task automatic present(input int tc, input bit p);
        time_cnt = tc[12:0];
        cycle = cur_cycle[12:0];
        pwm_in = p;
        if (tc == 0) begin
            win.delete();
            m_armed = 1;
            m_s0 = m_prev;
        end
        if (m_armed) win.push_back(p);
        if (m_armed && tc == cur_cycle - 1) begin
            q.push_back(decode_window(cur_cycle));
            m_armed = 0;
        end
        m_prev = p;
    endtask

    // mode 0: generator, 1: random noise, 2: two-pulse glitch
    task automatic run(input int mode, input int d, input int ph, input int lo, input int hi);
        bit p;
        for (int t = lo; t <= hi; t++) begin
            @(negedge clk);
            case (mode)
                1:       p = 1'($urandom_range(0, 1));
                2:       p = (t >= 100 && t < 200) || (t >= 300 && t < 400);
                default: p = gen(d, ph, cur_cycle, t);
            endcase
            present(t, p);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_duty"}, duty, 0);
        chk({nm, "_phase"}, phase, 0);
        chk({nm, "_over"}, over, 0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && started) begin
            while (q.size() != 0 && q[0].at < cnt) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL missing_valid: got none want strobe at %0d (now %0d)", q[0].at, cnt);
                void'(q.pop_front());
            end
            if (valid) begin
                if (q.size() == 0 || q[0].at != cnt) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL unexpected_valid: got strobe at %0d want none", cnt);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("err", err, x.e);
                    if (!x.e) begin
                        hold_d = x.d;
                        hold_p = x.ph;
                        hold_o = x.ov;
                    end
                    chk("duty", duty, hold_d);
                    chk("phase", phase, hold_p);
                    chk("over", over, hold_o);
                end
            end else begin
                chk("hold_duty", duty, hold_d);
                chk("hold_phase", phase, hold_p);
                chk("hold_over", over, hold_o);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        started = 1;

        cur_cycle = 5000;
        @(negedge clk);
        rst_n = 1'b1;
        present(0, gen(2500, 2500, 5000, 0));
        run(0, 2500, 2500, 1, 4999);
        run(0, 2500, 2500, 0, 4999);
        run(0, 2500, 1000, 0, 4999);
        run(0, 2500, 4000, 0, 4999);
        run(0, 1, 0, 0, 4999);
        run(0, 1, 1, 0, 4999);
        run(0, 2, 1, 0, 4999);
        run(0, 0, 0, 0, 4999);
        run(0, 5000, 0, 0, 4999);
        run(2, 0, 0, 0, 4999);
        run(0, 2500, 2500, 0, 4999);

        run(0, 2500, 2500, 0, 2000);
        run(0, 2500, 2500, 0, 4999);

        run(0, 2500, 2500, 0, 3000);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        m_prev = 0;
        m_armed = 0;
        hold_d = 0;
        hold_p = 0;
        hold_o = 0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        present(3001, gen(2500, 2500, 5000, 3001));
        run(0, 2500, 2500, 3002, 4999);
        run(0, 2500, 2500, 0, 4999);

        for (int w = 0; w < 150; w++) begin
            int c;
            c = $urandom_range(3, 40);
            cur_cycle = c;
            run(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, c), $urandom_range(0, c - 1), 0, c - 1);
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Recovers duty and phase from one ultrasound PWM output, measured against the shared time counter. It is the receive-side counterpart of the per-transducer PWM generator: a generated waveform looped back to PWM_IN yields the DUTY/PHASE pair that produced it. Used for built-in self-test and for bench cross-checking of the preconditioner and generator chain. One instance per monitored channel, clocked in the PWM clock domain.

## Interface
- WIDTH, 13: width of time, cycle, duty and phase values.
- CLK  in  1  PWM-domain clock.
- RST_N  in  1  asynchronous, active-low reset. One clock (CLK); reset is asynchronous and active-low.
- TIME_CNT  in  WIDTH  time counter, 0..CYCLE-1, +1 per CLK, aligned by the caller to the PWM_IN sample.
- CYCLE  in  WIDTH  period in CLK ticks (5000 at 200 MHz / 40 kHz). Must be stable for a whole window.
- PWM_IN  in  1  waveform under measurement.
- DUTY  out  WIDTH  measured high time in ticks.
- PHASE  out  WIDTH  measured pulse centre in ticks, 0..CYCLE-1.
- OVER  out  1  pulse wraps across the window boundary (fall seen before rise).
- VALID  out  1  one-cycle strobe: new measurement on DUTY/PHASE/OVER/ERR.
- ERR  out  1  qualifies VALID: window was not decodable; DUTY/PHASE/OVER keep their previous values.

## Operation
- Window: opens on the sample with TIME_CNT==0 and closes on the sample with TIME_CNT==CYCLE-1.
- Per sample: rise = PWM_IN & ~prev, fall = ~PWM_IN & prev. prev is the previous sample's PWM_IN, carried across window boundaries. An edge at the first sample of a window belongs to that window.
- Per window, record: rise count, fall count (each saturates at 2), TIME_CNT of the first rise (L) and of the first fall (R), and start level S = prev at the TIME_CNT==0 sample.
- Decode at close:
  - More than 1 rise or more than 1 fall: ERR.
  - No edges, S=0: DUTY=0, PHASE=0, OVER=0.
  - No edges, S=1: DUTY=CYCLE, PHASE=0, OVER=0.
  - Rise and fall, R>L: DUTY=R-L, OVER=0.
  - Rise and fall, R<L: DUTY=R-L+CYCLE, OVER=1.
  - Rise only: DUTY=CYCLE-L, OVER=0.
  - Fall only: L=0, DUTY=R, OVER=0.
  - PHASE = L + (DUTY>>1). If the result is >= CYCLE, subtract CYCLE.
  - All intermediates are WIDTH+1 bits.
- The decode inverts the generator's convention: the output is high on [PHASE-DUTY/2, PHASE-DUTY/2+DUTY) mod CYCLE.
- Resync: when TIME_CNT==0 arrives without a preceding CYCLE-1 close, the partial window is discarded with no VALID, and a new window opens.
- After reset, no VALID is issued until a full window (0 through CYCLE-1) has been observed.
- CYCLE==0 or CYCLE>2^WIDTH-1: no window ever closes; outputs hold.

## Timing
- Reset values: DUTY=0, PHASE=0, OVER=0, VALID=0, ERR=0. Internal prev=0, counts=0, window-armed=0.
- Input sampling is registered once.
- Pipeline:
  - Cycle k: PWM_IN/TIME_CNT with TIME_CNT==CYCLE-1 are presented.
  - k+1: the window's edge state is final and the difference/modulo stage is registered.
  - k+2: DUTY, PHASE, OVER and ERR are updated and VALID=1 for exactly one cycle.
- Fixed latency: 2 cycles from the closing sample to VALID.
- Back-to-back windows are supported: decode of window n overlaps capture of window n+1. The minimum CYCLE is 3.
- Outputs are stable between VALID strobes.
- Reset asserted mid-window or mid-pipeline: all state clears immediately, and no VALID is emitted for the interrupted window.

## Test plan
All cases use CYCLE=5000 and drive the generator loopback with TIME_CNT aligned. For each (DUTY, PHASE) setting, check from the 2nd window on:
- Centred pulse, (2500,2500): edges at 1250/3750 → DUTY=2500, PHASE=2500, OVER=0, ERR=0, one VALID per 5000 cycles, 2 cycles after TIME_CNT==4999.
- Underflow, (2500,1000): fall at 2250, rise at 4750 → DUTY=2500, PHASE=1000, OVER=1. Overflow, (2500,4000): fall at 250, rise at 2750 → DUTY=2500, PHASE=4000, OVER=1.
- Minimum pulses:
  - (1,0): rise at 0, fall at 1 → DUTY=1, PHASE=0.
  - (1,1) → DUTY=1, PHASE=1.
  - (2,1): rise at 0, fall at 2 → DUTY=2, PHASE=1.
- Static levels:
  - PWM_IN held 0 → DUTY=0, PHASE=0.
  - PWM_IN held 1 → DUTY=5000, PHASE=0, OVER=0.
- Glitch: two pulses in one window ([100,200) and [300,400)) → VALID with ERR=1 and previous DUTY/PHASE held. The next clean window gives ERR=0.
- Robustness:
  - TIME_CNT forced from 2000 to 0 → no VALID for the partial window; the next full window decodes normally.
  - RST_N pulsed low at TIME_CNT=3000 → all outputs 0 at once; the first VALID comes only after a complete 0..4999 window.
